// File: rtl/md_read_seq_pkg.sv
// Shared definitions for the CADR memory-data bus sequencers: state encodings
// and default bus geometry, common to the read and (future) write sequencers.
package md_read_seq_pkg;

    localparam int AW_DEFAULT      = 22;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TW_DEFAULT      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/md_read_seq_bus_timeout_ctr.sv
// Saturating bus-timeout counter with synchronous clear, count enable and a
// terminal-count flag raised when the count reaches TERM-1.
module bus_timeout_ctr #(
    parameter int TW   = 8,
    parameter int TERM = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TW-1:0] TERM_M1   = TW'(TERM - 1);
    localparam logic [TW-1:0] COUNT_MAX = '1;

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM_M1);

endmodule

// File: rtl/md_read_seq.sv
// Read-cycle sequencer for the 74S373 memory-data latches: one req/ack bus
// read, latch freeze, tri-state drive onto MD until the CPU takes the word.
module md_read_seq
    import md_read_seq_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TW      = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_take,
    output logic          cpu_busy,
    output logic          cpu_valid,
    output logic          cpu_nxm,
    output logic          bus_req,
    output logic [AW-1:0] bus_addr,
    input  logic          bus_ack,
    output logic          latch_hold_n,
    output logic          latch_oenb_n
);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic          busy_nxt;
    logic          valid_nxt;
    logic          nxm_nxt;
    logic          bus_req_nxt;
    logic [AW-1:0] bus_addr_nxt;
    logic          hold_n_nxt;
    logic          oenb_n_nxt;
    logic          ctr_clr;
    logic          ctr_en;
    logic          ctr_tc;

    bus_timeout_ctr #(
        .TW   (TW),
        .TERM (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .tc      (ctr_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cpu_busy     <= 1'b0;
            cpu_valid    <= 1'b0;
            cpu_nxm      <= 1'b0;
            bus_req      <= 1'b0;
            bus_addr     <= '0;
            latch_hold_n <= 1'b0;
            latch_oenb_n <= 1'b1;
        end else begin
            state        <= state_nxt;
            cpu_busy     <= busy_nxt;
            cpu_valid    <= valid_nxt;
            cpu_nxm      <= nxm_nxt;
            bus_req      <= bus_req_nxt;
            bus_addr     <= bus_addr_nxt;
            latch_hold_n <= hold_n_nxt;
            latch_oenb_n <= oenb_n_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy_nxt     = cpu_busy;
        valid_nxt    = cpu_valid;
        nxm_nxt      = cpu_nxm;
        bus_req_nxt  = bus_req;
        bus_addr_nxt = bus_addr;
        hold_n_nxt   = latch_hold_n;
        oenb_n_nxt   = latch_oenb_n;
        ctr_clr      = 1'b0;
        ctr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_nxt    = ST_WAIT;
                    busy_nxt     = 1'b1;
                    bus_req_nxt  = 1'b1;
                    bus_addr_nxt = cpu_addr;
                    hold_n_nxt   = 1'b1;
                    ctr_clr      = 1'b1;
                end
            end
            ST_WAIT: begin
                ctr_en = !bus_ack;
                // ACK is checked first so it beats a timeout on the same edge.
                if (bus_ack) begin
                    state_nxt   = ST_DRIVE;
                    bus_req_nxt = 1'b0;
                    hold_n_nxt  = 1'b0;
                end else if (ctr_tc) begin
                    state_nxt   = ST_DRIVE;
                    bus_req_nxt = 1'b0;
                    hold_n_nxt  = 1'b0;
                    nxm_nxt     = 1'b1;
                    valid_nxt   = 1'b1;
                end
            end
            ST_DRIVE: begin
                // Data path arrives with valid low: open the latch outputs one
                // cycle after the hold edge; a take seen before then is dropped.
                if (!cpu_valid) begin
                    valid_nxt  = 1'b1;
                    oenb_n_nxt = 1'b0;
                end else if (cpu_take) begin
                    state_nxt  = ST_RELEASE;
                    valid_nxt  = 1'b0;
                    nxm_nxt    = 1'b0;
                    oenb_n_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!bus_ack) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
